fetch_unit: RTL and testbench

Instruction fetch front end feeding the fetch/decode pipeline register with `f_instr`/`f_pc`. Generates sequential PCs and issues word requests to instruction memory over a valid/ready request channel. Accepts in-order, non-backpressurable responses into a small buffer and presents them to decode under a stall signal. Handles PC redirects from later stages by flushing buffered words and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0],
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  T              i_wdata,
    output T              o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, in-order response
// buffering toward decode, and redirect handling with stale-response drop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            f_valid,
    output logic [XLEN-1:0] f_instr,
    output logic [XLEN-1:0] f_pc
);

    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0]   SLOTS = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_accept;
    logic            w_rsp_keep;
    logic            w_pop;
    logic [CW:0]     w_occupied;
    logic [CW-1:0]   w_inflight_after_rsp;
    logic [XLEN-1:0] w_rsp_pc;
    fetch_entry_t    w_buf_wdata;
    fetch_entry_t    w_head;
    logic [CW-1:0]   w_buf_count;
    logic            w_buf_empty;
    logic            w_buf_full;
    logic [CW-1:0]   w_tag_count;
    logic            w_tag_empty;
    logic            w_tag_full;
    logic            w_unused;

    // Every slot is reserved at issue time, so a response can always be stored.
    assign w_occupied     = {1'b0, r_inflight} + {1'b0, w_buf_count};
    assign imem_req_valid = reset && !redirect_valid && (w_occupied < SLOTS);
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_inflight_after_rsp = r_inflight - CW'(imem_rsp_valid);
    assign w_rsp_keep = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop      = !w_buf_empty && !stall && !redirect_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= w_inflight_after_rsp + CW'(w_accept);
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old stream.
                r_pc       <= word_align(redirect_pc);
                r_drop_cnt <= w_inflight_after_rsp;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + XLEN'(INSTR_BYTES);
                end
                if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_fifo (
        .i_clock (clock),
        .i_rst_n (reset),
        .i_push  (w_accept),
        .i_pop   (imem_rsp_valid),
        .i_flush (1'b0),
        .i_wdata (r_pc),
        .o_rdata (w_rsp_pc),
        .o_count (w_tag_count),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full)
    );

    assign w_buf_wdata = '{pc: w_rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_buf_fifo (
        .i_clock (clock),
        .i_rst_n (reset),
        .i_push  (w_rsp_keep),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_buf_wdata),
        .o_rdata (w_head),
        .o_count (w_buf_count),
        .o_empty (w_buf_empty),
        .o_full  (w_buf_full)
    );

    assign f_valid = !w_buf_empty;
    assign f_instr = f_valid ? w_head.instr : BUBBLE_INSTR;
    assign f_pc    = f_valid ? w_head.pc : '0;

    assign w_unused = ^{w_tag_count, w_tag_empty, w_tag_full, w_buf_full};

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a queue-based memory and fetch-stream
// model predicts requests, delivered words and redirect behaviour.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_f_valid;
    logic [31:0] w_f_instr;
    logic [31:0] w_f_pc;
    logic        w_ready    = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redir_pc = 32'h0;
    logic        w_stall    = 1'b0;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          drop        = 0;
    int          lat_min     = 1;
    int          lat_max     = 1;
    logic [31:0] exp_req_pc  = 32'h0;
    req_t        mq[$];
    ent_t        bq[$];
    logic [31:0] wq[$];
    ent_t        wfq[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .f_valid        (f_valid),
        .f_instr        (f_instr),
        .f_pc           (f_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redir_pc),
        .stall          (w_stall),
        .f_valid        (w_f_valid),
        .f_instr        (w_f_instr),
        .f_pc           (w_f_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit rdy, input bit stl, input bit rd, input logic [31:0] rpc);
        bit   rsp;
        bit   exp_rv;
        req_t r;
        ent_t e;
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mdata(mq[0].addr) : $urandom;
        #1;
        exp_rv = ((mq.size() + bq.size()) < DEPTH) && !rd;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, exp_req_pc);
        chk("f_valid", 32'(f_valid), 32'(bq.size() > 0));
        chk("f_pc", f_pc, (bq.size() > 0) ? bq[0].pc : 32'h0);
        chk("f_instr", f_instr, (bq.size() > 0) ? bq[0].instr : 32'h0);
        if (!rd && !stl && bq.size() > 0) void'(bq.pop_front());
        if (rsp) begin
            r = mq.pop_front();
            if (drop > 0) drop--;
            else if (!rd) begin
                e.pc    = r.addr;
                e.instr = mdata(r.addr);
                bq.push_back(e);
            end
        end
        if (rd) begin
            bq.delete();
            drop       = mq.size();
            exp_req_pc = rpc & ~32'h3;
        end else if (exp_rv && rdy) begin
            r.addr = exp_req_pc;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mq.push_back(r);
            exp_req_pc = exp_req_pc + 32'd4;
        end
        cyc++;
        @(negedge clock);
    endtask

    // Single-cycle memory behind the wrap-around instance.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_rsp_valid <= 1'b0;
            w_rsp_data  <= 32'h0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= mdata(w_req_addr);
        end
    end

    always @(negedge clock) begin
        #1;
        if (reset && w_req_valid && wq.size() < 8) wq.push_back(w_req_addr);
        if (reset && w_f_valid && wfq.size() < 8) wfq.push_back('{w_f_pc, w_f_instr});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wexp [3];
        bit          seen;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_f_valid", 32'(f_valid), 32'h0);
        chk("rst_f_instr", f_instr, 32'h0);
        chk("rst_f_pc", f_pc, 32'h0);
        chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
        @(negedge clock);
        reset = 1'b1;

        // Streaming with a 1-cycle memory.
        repeat (30) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Decode stall for 5 cycles, then release.
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // 3-cycle memory with toggling ready.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 60; i++) cycle(1'(i % 2), 1'b0, 1'b0, 32'h0);

        // Redirect with two responses in flight.
        for (int i = 0; i < 20 && mq.size() != 2; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        chk("redirect_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 12 && !f_valid; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redirect_first_pc", f_pc, 32'h0000_0100);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect coinciding with a response while stalled.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 40 && !(mq.size() > 0 && mq[0].due <= cyc && bq.size() > 0); i++)
            cycle(1'b1, bq.size() < 2, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("flush_f_valid", 32'(f_valid), 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random mix of latency, ready, stall and redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 3,
                  $urandom_range(19, 0) == 0, $urandom);

        // Asynchronous reset while the wrap instance holds a word.
        lat_min = 1; lat_max = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (w_f_valid) seen = 1'b1;
            else cycle(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("wrap_f_valid_before_rst", 32'(w_f_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_wrap_f_valid", 32'(w_f_valid), 32'h0);
        chk("async_rst_f_valid", 32'(f_valid), 32'h0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("async_rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
        mq.delete();
        bq.delete();
        drop       = 0;
        exp_req_pc = 32'h0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Wrap-around sequence captured after the first reset release.
        for (int i = 0; i < 3; i++) begin
            chk("wrap_req_addr", (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx, wexp[i]);
            chk("wrap_f_pc", (i < wfq.size()) ? wfq[i].pc : 32'hxxxx_xxxx, wexp[i]);
            chk("wrap_f_instr", (i < wfq.size()) ? wfq[i].instr : 32'hxxxx_xxxx, mdata(wexp[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
